// File: rtl/pic_blend_stream.sv
// pic_blend_stream
//   Streaming two-layer compositor. A background raster stream is blended with
//   an overlay (picture-in-picture) raster stream inside a window placed at
//   frame start, then written out as DRAM data words plus one burst command
//   per BURST pixels.
//
// Ports
//   CLK, RST_N                 clock, asynchronous active-low reset
//   START / BUSY / END / ERR   frame control: rising START runs one frame,
//                              END pulses on completion or rejection,
//                              ERR is sticky for an invalid window
//   PIP_X, PIP_Y               overlay top-left position
//   PIP_OPACITY, ALPHA_MODE    global alpha, per-pixel alpha enable
//   bg_data/valid/ready        background stream {R,G,B,X}
//   ov_data/valid/ready        overlay stream {R,G,B,A}
//   wr_afull                   write FIFO almost full (stalls acceptance only)
//   data_in/data_we            write data {strb, R, G, B, 8'hFF}
//   ctrl_in/ctrl_we            write command {len, byte address}
//
// Build option
//   PIC_BLEND_CHROMAKEY_EN     adds KEY_RGB; overlay pixels matching the key
//                              are made fully transparent (still consumed).
//
// state  | meaning
// IDLE   | waiting for a START rising edge
// CHECK  | latch window/alpha settings, validate window
// RUN    | accepting pixels
// REJECT | invalid window: set ERR, pulse END
// FLUSH  | all pixels accepted, draining the pipeline
module pic_blend_stream #(
  parameter int          BACK_W    = 1600,
  parameter int          BACK_H    = 900,
  parameter int          PIP_W     = 640,
  parameter int          PIP_H     = 480,
  parameter int          BURST     = 64,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          CW        = 12
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  output logic          BUSY,
  output logic          END,
  output logic          ERR,
  input  logic [CW-1:0] PIP_X,
  input  logic [CW-1:0] PIP_Y,
  input  logic [7:0]    PIP_OPACITY,
  input  logic          ALPHA_MODE,
`ifdef PIC_BLEND_CHROMAKEY_EN
  input  logic [23:0]   KEY_RGB,
`endif
  input  logic [31:0]   bg_data,
  input  logic          bg_valid,
  output logic          bg_ready,
  input  logic [31:0]   ov_data,
  input  logic          ov_valid,
  output logic          ov_ready,
  input  logic          wr_afull,
  output logic [35:0]   data_in,
  output logic          data_we,
  output logic [39:0]   ctrl_in,
  output logic          ctrl_we
);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_RUN, S_REJECT, S_FLUSH} state_t;

  localparam logic [CW:0]   BACK_W_C = (CW+1)'(BACK_W);
  localparam logic [CW:0]   BACK_H_C = (CW+1)'(BACK_H);
  localparam logic [CW:0]   PIP_W_C  = (CW+1)'(PIP_W);
  localparam logic [CW:0]   PIP_H_C  = (CW+1)'(PIP_H);
  localparam logic [CW-1:0] X_LAST   = CW'(BACK_W - 1);
  localparam logic [CW-1:0] Y_LAST   = CW'(BACK_H - 1);
  localparam logic [7:0]    B_LAST   = 8'(BURST - 1);
  localparam logic [7:0]    B_LEN    = 8'(BURST);

  // (s + 128 + ((s + 128) >> 8)) >> 8 == round(s / 255); never exceeds 16 bits
  // for s <= 255*255.
  function automatic logic [7:0] rnd255(input logic [15:0] s);
    logic [15:0] t;
    t = s + 16'd128;
    t = t + {8'd0, t[15:8]};
    return t[15:8];
  endfunction

  function automatic logic [15:0] blend(input logic [7:0] ov, input logic [7:0] bg,
                                        input logic [7:0] a);
    return {8'd0, ov} * {8'd0, a} + {8'd0, bg} * {8'd0, 8'd255 - a};
  endfunction

  state_t          state_q;
  logic            start_q, err_q, end_q, mode_q;
  logic [CW-1:0]   px_q, py_q, x_q, y_q;
  logic [7:0]      op_q, bcnt_q;
  logic [31:0]     addr_q;

  logic            v0_q, first0_q, v1_q, first1_q;
  logic [23:0]     bg0_q, ov0_q;
  logic [7:0]      a0_q;
  logic [31:0]     addr0_q, addr1_q;
  logic [15:0]     sr_q, sg_q, sb_q;
  logic            data_we_q, ctrl_we_q;
  logic [35:0]     data_in_q;
  logic [39:0]     ctrl_in_q;

  logic [CW:0]     chk_x, chk_y, px_end, py_end;
  logic            win_ok, inwin, accept, last_pix, key_hit;
  logic [7:0]      a_scaled, a_pix;
  logic            unused_bg_x;

  assign unused_bg_x = ^bg_data[7:0];

  assign chk_x  = {1'b0, PIP_X} + PIP_W_C;
  assign chk_y  = {1'b0, PIP_Y} + PIP_H_C;
  assign win_ok = (chk_x <= BACK_W_C) && (chk_y <= BACK_H_C);

  assign px_end = {1'b0, px_q} + PIP_W_C;
  assign py_end = {1'b0, py_q} + PIP_H_C;
  assign inwin  = (x_q >= px_q) && ({1'b0, x_q} < px_end) &&
                  (y_q >= py_q) && ({1'b0, y_q} < py_end);

  assign accept   = (state_q == S_RUN) && bg_valid && !wr_afull && (!inwin || ov_valid);
  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);
  assign bg_ready = accept;
  assign ov_ready = accept && inwin;

`ifdef PIC_BLEND_CHROMAKEY_EN
  logic [23:0] key_q;
  assign key_hit = (ov_data[31:8] == key_q);
`else
  assign key_hit = 1'b0;
`endif

  assign a_scaled = mode_q ? rnd255({8'd0, op_q} * {8'd0, ov_data[7:0]}) : op_q;
  assign a_pix    = (inwin && !key_hit) ? a_scaled : 8'd0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      end_q   <= 1'b0;
      mode_q  <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      op_q    <= '0;
      bcnt_q  <= '0;
      addr_q  <= '0;
`ifdef PIC_BLEND_CHROMAKEY_EN
      key_q   <= '0;
`endif
    end else begin
      start_q <= START;
      end_q   <= 1'b0;
      case (state_q)
        S_IDLE: if (START && !start_q) state_q <= S_CHECK;
        S_CHECK: begin
          px_q   <= PIP_X;
          py_q   <= PIP_Y;
          op_q   <= PIP_OPACITY;
          mode_q <= ALPHA_MODE;
`ifdef PIC_BLEND_CHROMAKEY_EN
          key_q  <= KEY_RGB;
`endif
          x_q    <= '0;
          y_q    <= '0;
          bcnt_q <= '0;
          addr_q <= BASE_ADDR;
          if (win_ok) begin
            err_q   <= 1'b0;
            state_q <= S_RUN;
          end else begin
            state_q <= S_REJECT;
          end
        end
        S_RUN: if (accept) begin
          addr_q <= addr_q + 32'd4;
          bcnt_q <= (bcnt_q == B_LAST) ? 8'd0 : bcnt_q + 8'd1;
          if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= y_q + 1'b1;
          end else begin
            x_q <= x_q + 1'b1;
          end
          if (last_pix) state_q <= S_FLUSH;
        end
        S_REJECT: begin
          err_q   <= 1'b1;
          end_q   <= 1'b1;
          state_q <= S_IDLE;
        end
        S_FLUSH: begin
          // Stage 1 holding the last word with stage 0 empty means the final
          // data_we fires next cycle; END is aligned with it.
          if (v1_q && !v0_q) begin
            end_q   <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // capture -> multiply -> round; data_we lands 3 cycles after accept.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v0_q      <= 1'b0;
      first0_q  <= 1'b0;
      bg0_q     <= '0;
      ov0_q     <= '0;
      a0_q      <= '0;
      addr0_q   <= '0;
      v1_q      <= 1'b0;
      first1_q  <= 1'b0;
      sr_q      <= '0;
      sg_q      <= '0;
      sb_q      <= '0;
      addr1_q   <= '0;
      data_we_q <= 1'b0;
      ctrl_we_q <= 1'b0;
      data_in_q <= '0;
      ctrl_in_q <= '0;
    end else begin
      v0_q <= accept;
      if (accept) begin
        bg0_q    <= bg_data[31:8];
        ov0_q    <= ov_data[31:8];
        a0_q     <= a_pix;
        first0_q <= (bcnt_q == 8'd0);
        addr0_q  <= addr_q;
      end
      v1_q <= v0_q;
      if (v0_q) begin
        sr_q     <= blend(ov0_q[23:16], bg0_q[23:16], a0_q);
        sg_q     <= blend(ov0_q[15:8],  bg0_q[15:8],  a0_q);
        sb_q     <= blend(ov0_q[7:0],   bg0_q[7:0],   a0_q);
        first1_q <= first0_q;
        addr1_q  <= addr0_q;
      end
      data_we_q <= v1_q;
      ctrl_we_q <= v1_q && first1_q;
      if (v1_q) begin
        data_in_q <= {4'hF, rnd255(sr_q), rnd255(sg_q), rnd255(sb_q), 8'hFF};
        if (first1_q) ctrl_in_q <= {B_LEN, addr1_q};
      end
    end
  end

  assign BUSY    = (state_q != S_IDLE);
  assign END     = end_q;
  assign ERR     = err_q;
  assign data_we = data_we_q;
  assign data_in = data_in_q;
  assign ctrl_we = ctrl_we_q;
  assign ctrl_in = ctrl_in_q;

endmodule

// File: tb/tb_pic_blend_stream.sv
// Directed bench for pic_blend_stream on a 64x4 background with a 16x2 overlay.
module tb_pic_blend_stream;
  localparam int BW = 64, BH = 4, PW = 16, PH = 2, BU = 64, NPIX = BW * BH;

  logic        CLK = 1'b0, RST_N = 1'b0, START = 1'b0;
  logic        BUSY, END, ERR;
  logic [11:0] PIP_X = '0, PIP_Y = '0;
  logic [7:0]  PIP_OPACITY = '0;
  logic        ALPHA_MODE = 1'b0;
  logic [31:0] bg_data = '0, ov_data = '0;
  logic        bg_valid = 1'b1, ov_valid = 1'b1, bg_ready, ov_ready;
  logic        wr_afull = 1'b0;
  logic [35:0] data_in;
  logic        data_we;
  logic [39:0] ctrl_in;
  logic        ctrl_we;
`ifdef PIC_BLEND_CHROMAKEY_EN
  logic [23:0] key_rgb = 24'h123456;
`endif

  pic_blend_stream #(.BACK_W(BW), .BACK_H(BH), .PIP_W(PW), .PIP_H(PH), .BURST(BU),
                     .BASE_ADDR(32'h0), .CW(12)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .BUSY(BUSY), .END(END), .ERR(ERR),
    .PIP_X(PIP_X), .PIP_Y(PIP_Y), .PIP_OPACITY(PIP_OPACITY), .ALPHA_MODE(ALPHA_MODE),
`ifdef PIC_BLEND_CHROMAKEY_EN
    .KEY_RGB(key_rgb),
`endif
    .bg_data(bg_data), .bg_valid(bg_valid), .bg_ready(bg_ready),
    .ov_data(ov_data), .ov_valid(ov_valid), .ov_ready(ov_ready),
    .wr_afull(wr_afull), .data_in(data_in), .data_we(data_we),
    .ctrl_in(ctrl_in), .ctrl_we(ctrl_we));

  always #5 CLK = ~CLK;

  int tests_run = 0, tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stimulus patterns, indexed by stream position.
  function automatic logic [31:0] bg_pix(input int sel, input int i);
    case (sel)
      0:       return 32'h0000FF00;
      1:       return {8'd100, 16'h0000, 8'h00};
      default: return {8'(i * 7), 8'(i * 13 + 5), 8'(255 - i), 8'hAA};
    endcase
  endfunction

  function automatic logic [31:0] ov_pix(input int sel, input int i);
    case (sel)
      0:       return 32'hFF000000;
      1:       return {8'd200, 16'h0000, 8'h80};
      2:       return {24'h112233, (i % 2 == 1) ? 8'hFF : 8'h00};
      default: return {8'(i * 3 + 1), 8'(200 - i), 8'(i * 11), 8'(i * 17)};
    endcase
  endfunction

  function automatic int rdiv255(input int s);
    return (2 * s + 255) / 510;
  endfunction

  function automatic logic [35:0] exp_pix(input int k, input int px, input int py,
                                          input int op, input bit mode,
                                          input int bs, input int os);
    int x, y, a;
    logic [31:0] b, o;
    logic [7:0] r, g, bl;
    x = k % BW;
    y = k / BW;
    b = bg_pix(bs, k);
    o = '0;
    a = 0;
    if (x >= px && x < px + PW && y >= py && y < py + PH) begin
      o = ov_pix(os, (y - py) * PW + (x - px));
      a = mode ? rdiv255(op * int'(o[7:0])) : op;
    end
    r  = 8'(rdiv255(int'(o[31:24]) * a + int'(b[31:24]) * (255 - a)));
    g  = 8'(rdiv255(int'(o[23:16]) * a + int'(b[23:16]) * (255 - a)));
    bl = 8'(rdiv255(int'(o[15:8])  * a + int'(b[15:8])  * (255 - a)));
    return {4'hF, r, g, bl, 8'hFF};
  endfunction

  // Stream position bookkeeping and input driving.
  int   bg_idx = 0, ov_idx = 0, bg_sel = 0, ov_sel = 0;
  logic idx_clr = 1'b0;
  always @(posedge CLK) begin
    if (idx_clr) begin
      bg_idx <= 0;
      ov_idx <= 0;
    end else begin
      if (bg_ready) bg_idx <= bg_idx + 1;
      if (ov_ready) ov_idx <= ov_idx + 1;
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      bg_data = bg_pix(bg_sel, bg_idx);
      ov_data = ov_pix(ov_sel, ov_idx);
    end
  end

  // Output capture.
  logic        mon_clr = 1'b0;
  logic [35:0] out_q[$];
  logic [39:0] ctrl_q[$];
  int          ctrl_orphan = 0, end_cnt = 0, end_no_we = 0;
  always @(negedge CLK) begin
    if (mon_clr) begin
      out_q.delete();
      ctrl_q.delete();
      ctrl_orphan = 0;
      end_cnt = 0;
      end_no_we = 0;
    end else begin
      if (data_we) out_q.push_back(data_in);
      if (ctrl_we) begin
        ctrl_q.push_back(ctrl_in);
        if (!data_we) ctrl_orphan++;
      end
      if (END) begin
        end_cnt++;
        if (!data_we) end_no_we++;
      end
    end
  end

  function automatic logic [35:0] pix_at(input int k);
    if (k < out_q.size()) return out_q[k];
    return 'x;
  endfunction

  function automatic logic [39:0] ctrl_at(input int k);
    if (k < ctrl_q.size()) return ctrl_q[k];
    return 'x;
  endfunction

  task automatic run_frame(input string nm, input int px, input int py, input int op,
                           input bit mode, input int bs, input int os, input bit afull_test);
    int cyc, afull_cnt, we_in_afull;
    bit done;
    @(negedge CLK);
    PIP_X = 12'(px);
    PIP_Y = 12'(py);
    PIP_OPACITY = 8'(op);
    ALPHA_MODE = mode;
    bg_sel = bs;
    ov_sel = os;
    idx_clr = 1'b1;
    mon_clr = 1'b1;
    @(negedge CLK);
    idx_clr = 1'b0;
    mon_clr = 1'b0;
    START = 1'b1;
    cyc = 0;
    done = 1'b0;
    afull_cnt = 0;
    we_in_afull = 0;
    while (!done && cyc < 3000) begin
      @(negedge CLK);
      cyc++;
      if (cyc == 3)   START = 1'b0;
      if (cyc == 100) START = 1'b1;
      if (cyc == 103) START = 1'b0;
      if (afull_test) begin
        if (afull_cnt == 0 && bg_idx >= 40) begin
          wr_afull = 1'b1;
          afull_cnt = 1;
        end else if (afull_cnt >= 1 && afull_cnt <= 20) begin
          if (data_we) we_in_afull++;
          if (afull_cnt == 5) check({nm, "_afull_stall"}, {62'd0, bg_ready, ov_ready}, 64'd0);
          afull_cnt++;
          if (afull_cnt > 20) wr_afull = 1'b0;
        end
      end
      if (END) done = 1'b1;
    end
    START = 1'b0;
    wr_afull = 1'b0;
    check({nm, "_end_seen"}, 64'(done), 64'd1);
    @(negedge CLK);
    check({nm, "_end_pulse"}, 64'(END), 64'd0);
    repeat (3) @(negedge CLK);
    check({nm, "_busy"}, 64'(BUSY), 64'd0);
    check({nm, "_err"}, 64'(ERR), 64'd0);
    check({nm, "_we_count"}, 64'(out_q.size()), 64'(NPIX));
    check({nm, "_ctrl_count"}, 64'(ctrl_q.size()), 64'(NPIX / BU));
    check({nm, "_ctrl_orphan"}, 64'(ctrl_orphan), 64'd0);
    check({nm, "_end_count"}, 64'(end_cnt), 64'd1);
    check({nm, "_end_with_we"}, 64'(end_no_we), 64'd0);
    check({nm, "_bg_used"}, 64'(bg_idx), 64'(NPIX));
    check({nm, "_ov_used"}, 64'(ov_idx), 64'(PW * PH));
    if (afull_test) begin
      check({nm, "_afull_seen"}, 64'(afull_cnt), 64'd21);
      check({nm, "_afull_we_le3"}, 64'(we_in_afull <= 3), 64'd1);
    end
    for (int k = 0; k < NPIX / BU; k++)
      check($sformatf("%s_ctrl%0d", nm, k), 64'(ctrl_at(k)), 64'({8'(BU), 32'(k * BU * 4)}));
    for (int k = 0; k < NPIX; k++)
      check($sformatf("%s_pix%0d", nm, k), 64'(pix_at(k)),
            64'(exp_pix(k, px, py, op, mode, bs, os)));
  endtask

  initial begin
    bit seen;
    #12;
    check("rst_busy", 64'(BUSY), 64'd0);
    check("rst_end", 64'(END), 64'd0);
    check("rst_err", 64'(ERR), 64'd0);
    check("rst_we", {62'd0, data_we, ctrl_we}, 64'd0);
    check("rst_data", 64'(data_in), 64'd0);
    check("rst_ctrl", 64'(ctrl_in), 64'd0);
    check("rst_ready", {62'd0, bg_ready, ov_ready}, 64'd0);
    @(negedge CLK);
    RST_N = 1'b1;

    // Full-opacity window on a solid background.
    run_frame("A", 8, 1, 255, 1'b0, 0, 0, 1'b0);
    check("A_in_first", 64'(pix_at(72)), 64'h0_F_FF0000FF);
    check("A_left_out", 64'(pix_at(71)), 64'h0_F_0000FFFF);
    check("A_in_last", 64'(pix_at(151)), 64'h0_F_FF0000FF);
    check("A_right_out", 64'(pix_at(152)), 64'h0_F_0000FFFF);
    check("A_row0", 64'(pix_at(8)), 64'h0_F_0000FFFF);
    check("A_ctrl1", 64'(ctrl_at(1)), 64'h40_00000100);

    // Half opacity: 200 over 100 at a=128 -> 150.
    run_frame("B", 8, 1, 128, 1'b0, 1, 1, 1'b0);
    check("B_r150", 64'(pix_at(72)), 64'h0_F_960000FF);
    check("B_bg", 64'(pix_at(0)), 64'h0_F_640000FF);

    // Zero opacity passes the background unchanged.
    run_frame("C", 8, 1, 0, 1'b0, 2, 3, 1'b0);
    check("C_bg_exact", 64'(pix_at(72)), 64'h0_F_F8ADB7FF);

    // Per-pixel alpha at the origin: alpha 0 / 255 alternate.
    run_frame("D", 0, 0, 255, 1'b1, 2, 2, 1'b0);
    check("D_alpha0", 64'(pix_at(0)), 64'h0_F_0005FFFF);
    check("D_alpha255", 64'(pix_at(1)), 64'h0_F_112233FF);

    // Window one pixel too far right is rejected.
    @(negedge CLK);
    PIP_X = 12'(BW - PW + 1);
    PIP_Y = 12'd1;
    mon_clr = 1'b1;
    @(negedge CLK);
    mon_clr = 1'b0;
    START = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (END) seen = 1'b1;
    end
    check("rej_end", 64'(seen), 64'd1);
    check("rej_err", 64'(ERR), 64'd1);
    START = 1'b0;
    repeat (5) @(negedge CLK);
    check("rej_busy", 64'(BUSY), 64'd0);
    check("rej_no_write", 64'(out_q.size() + ctrl_q.size()), 64'd0);
    check("rej_err_sticky", 64'(ERR), 64'd1);

    // Window touching the bottom-right corner, with write back-pressure.
    run_frame("E", BW - PW, BH - PH, 200, 1'b1, 2, 3, 1'b1);

    // Reset in the middle of a frame, then a clean frame.
    @(negedge CLK);
    PIP_X = 12'd20;
    PIP_Y = 12'd1;
    PIP_OPACITY = 8'd77;
    ALPHA_MODE = 1'b0;
    bg_sel = 2;
    ov_sel = 3;
    idx_clr = 1'b1;
    @(negedge CLK);
    idx_clr = 1'b0;
    START = 1'b1;
    repeat (60) @(negedge CLK);
    check("abort_busy_pre", 64'(BUSY), 64'd1);
    #2 RST_N = 1'b0;
    #1;
    check("abort_busy", 64'(BUSY), 64'd0);
    check("abort_we", {62'd0, data_we, ctrl_we}, 64'd0);
    check("abort_data", 64'(data_in), 64'd0);
    check("abort_ctrl", 64'(ctrl_in), 64'd0);
    check("abort_ready", {61'd0, bg_ready, ov_ready, END}, 64'd0);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    run_frame("R", 20, 1, 77, 1'b0, 2, 3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
